// File: rtl/cache_init_pkg.sv
// Shared types and geometry helpers for the tag-store init/flush sequencer.
package cache_init_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    DRAIN,
    SWEEP,
    DONE
  } state_t;

  function automatic int unsigned lines_per_bank(input int unsigned cache_size,
                                                 input int unsigned line_size,
                                                 input int unsigned num_banks,
                                                 input int unsigned num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  // Must agree with the tag store's CS_LINE_SEL_BITS; one bit minimum for a single-line bank.
  function automatic int unsigned line_sel_bits(input int unsigned lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

endpackage

// File: rtl/cache_line_walker.sv
// Enable-gated wrapping line counter; last flags the final line of the bank.
module cache_line_walker #(
  parameter int unsigned LINES = 32,
  parameter int unsigned W     = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_IDX = W'(LINES - 1);

  assign last = (count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/cache_init_flush.sv
// Tag-store init and invalidate-flush sequencer for one cache bank.
//
//   state | meaning
//   INIT  | post-reset sweep clearing every line
//   IDLE  | bank open to core requests, flush accepted
//   DRAIN | waiting for pipeline and MSHR to empty
//   SWEEP | flush sweep clearing every line
//   DONE  | flush response pending
module cache_init_flush
  import cache_init_pkg::*;
#(
  parameter int unsigned CACHE_SIZE = 1024,
  parameter int unsigned LINE_SIZE  = 16,
  parameter int unsigned NUM_BANKS  = 1,
  parameter int unsigned NUM_WAYS   = 1,
  parameter int unsigned BANK_ID    = 0,
  localparam int unsigned LINES_PER_BANK = lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
  localparam int unsigned LINE_SEL_BITS  = line_sel_bits(LINES_PER_BANK)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     pipe_empty,
  input  logic                     flush_req_valid,
  output logic                     flush_req_ready,
  output logic                     flush_rsp_valid,
  input  logic                     flush_rsp_ready,
  output logic                     init,
  output logic [LINE_SEL_BITS-1:0] line_sel,
  output logic                     busy
);

  state_t                   state, state_next;
  logic                     walk_en;
  logic                     walk_last;
  logic [LINE_SEL_BITS-1:0] walk_count;

  cache_line_walker #(
    .LINES (LINES_PER_BANK),
    .W     (LINE_SEL_BITS)
  ) u_walker (
    .clk   (clk),
    .reset (reset),
    .en    (walk_en),
    .count (walk_count),
    .last  (walk_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    walk_en         = 1'b0;
    init            = 1'b0;
    busy            = 1'b1;
    flush_req_ready = 1'b0;
    flush_rsp_valid = 1'b0;
    line_sel        = walk_count;
    case (state)
      INIT, SWEEP: begin
        walk_en = ~stall;
        init    = ~stall;
        if (~stall && walk_last) begin
          state_next = (state == INIT) ? IDLE : DONE;
        end
      end
      IDLE: begin
        busy            = 1'b0;
        flush_req_ready = 1'b1;
        if (flush_req_valid) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_next = SWEEP;
        end
      end
      DONE: begin
        flush_rsp_valid = 1'b1;
        if (flush_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase
    // Reset is synchronous, so the decoded outputs are masked while it is held.
    if (reset) begin
      walk_en         = 1'b0;
      init            = 1'b0;
      busy            = 1'b1;
      flush_req_ready = 1'b0;
      flush_rsp_valid = 1'b0;
      line_sel        = '0;
    end
  end

`ifdef DBG_TRACE_CACHE
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT && walk_en && walk_count == '0)
        $display("%t: bank%0d init start", $time, BANK_ID);
      if (flush_req_valid && flush_req_ready)
        $display("%t: bank%0d flush accepted", $time, BANK_ID);
      if (flush_rsp_valid && flush_rsp_ready)
        $display("%t: bank%0d flush done", $time, BANK_ID);
    end
  end
`endif

endmodule

// File: tb/tb_cache_init_flush.sv
// Randomized bench for cache_init_flush against a line-count reference model.
module tb_cache_init_flush;

  localparam int L   = 32;
  localparam int LSB = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           stall = 1'b0;
  logic           pipe_empty = 1'b1;
  logic           flush_req_valid = 1'b0;
  logic           flush_req_ready;
  logic           flush_rsp_valid;
  logic           flush_rsp_ready = 1'b0;
  logic           init;
  logic [LSB-1:0] line_sel;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int clears[L];

  cache_init_flush #(
    .CACHE_SIZE (1024),
    .LINE_SIZE  (16),
    .NUM_BANKS  (1),
    .NUM_WAYS   (2),
    .BANK_ID    (0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .pipe_empty      (pipe_empty),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .flush_rsp_valid (flush_rsp_valid),
    .flush_rsp_ready (flush_rsp_ready),
    .init            (init),
    .line_sel        (line_sel),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model of a sweep: a line pointer that advances on every unstalled cycle
  // until all L lines have been cleared. Deviations are returned to the calling test.
  task automatic run_sweep(input int pct, input logic [63:0] mask, input bit req_hold,
                           input int abort_line, output int dev, output int cycles,
                           output int stalls, output string msg);
    int line;
    logic exp_init;
    logic [LSB-1:0] exp_sel;
    line = 0; dev = 0; cycles = 0; stalls = 0; msg = "";
    for (int i = 0; i < L; i++) clears[i] = 0;
    for (int g = 0; g < 400 && line < L && line != abort_line; g++) begin
      next_cycle();
      reset           = 1'b0;
      stall           = (cycles < 64 && mask[cycles]) || ($urandom_range(99) < pct);
      flush_req_valid = req_hold ? 1'b1 : 1'($urandom_range(1));
      pipe_empty      = 1'($urandom_range(1));
      flush_rsp_ready = 1'($urandom_range(1));
      @(negedge clk);
      exp_init = ~stall;
      exp_sel  = LSB'(line);
      if (init !== exp_init || line_sel !== exp_sel || busy !== 1'b1 ||
          flush_req_ready !== 1'b0 || flush_rsp_valid !== 1'b0) begin
        if (dev == 0)
          msg = $sformatf("cycle %0d got init=%b sel=%0d busy=%b rdy=%b rsp=%b want init=%b sel=%0d busy=1 rdy=0 rsp=0",
                          cycles, init, line_sel, busy, flush_req_ready, flush_rsp_valid, exp_init, exp_sel);
        dev++;
      end
      if (init === 1'b1) clears[int'(line_sel)]++;
      if (stall) stalls++;
      else line++;
      cycles++;
    end
    if (line < L && line != abort_line) begin
      dev++;
      msg = "sweep did not finish within cycle budget";
    end
  endtask

  task automatic apply_reset();
    next_cycle();
    reset = 1'b1; stall = 1'b0; flush_req_valid = 1'b0; flush_rsp_ready = 1'b0; pipe_empty = 1'b1;
    next_cycle();
  endtask

  function automatic int bad_lines();
    int n = 0;
    for (int i = 0; i < L; i++) if (clears[i] != 1) n++;
    return n;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      reset = 1'b1;
      stall = 1'($urandom_range(1));
      flush_req_valid = 1'($urandom_range(1));
      flush_rsp_ready = 1'($urandom_range(1));
      pipe_empty = 1'($urandom_range(1));
      @(negedge clk);
      total++;
      if (init !== 1'b0 || busy !== 1'b1 || flush_req_ready !== 1'b0 ||
          flush_rsp_valid !== 1'b0 || line_sel !== '0)
        begin bad++; $display("FAIL reset_outputs: got init=%b busy=%b rdy=%b rsp=%b sel=%0d want 0 1 0 0 0",
                              init, busy, flush_req_ready, flush_rsp_valid, line_sel); end
    end
  endtask

  task automatic check_sweep_result(input string name, input int dev, input string msg);
    total++;
    if (dev !== 0) begin bad++; $display("FAIL %s_sweep: %0d bad cycles, first %s", name, dev, msg); end
    total++;
    if (bad_lines() !== 0) begin bad++; $display("FAIL %s_clear_once: %0d lines not cleared exactly once, want 0", name, bad_lines()); end
  endtask

  task automatic check_idle_after(input string name, input int cycles);
    next_cycle();
    stall = 1'($urandom_range(1)); flush_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || flush_req_ready !== 1'b1 || init !== 1'b0)
      begin bad++; $display("FAIL %s_busy_fall: cycle %0d got busy=%b rdy=%b init=%b want 0 1 0", name, cycles, busy, flush_req_ready, init); end
  endtask

  task automatic test_powerup();
    int dev, cycles, stalls; string msg;
    run_sweep(0, '0, 1'b0, -1, dev, cycles, stalls, msg);
    check_sweep_result("powerup", dev, msg);
    check_idle_after("powerup", cycles);
  endtask

  task automatic test_idle();
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      stall = 1'($urandom_range(1)); pipe_empty = 1'($urandom_range(1));
      flush_req_valid = 1'b0; flush_rsp_ready = 1'($urandom_range(1));
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || flush_req_ready !== 1'b1 || init !== 1'b0 || flush_rsp_valid !== 1'b0)
        begin bad++; $display("FAIL idle_hold: got busy=%b rdy=%b init=%b rsp=%b want 0 1 0 0", busy, flush_req_ready, init, flush_rsp_valid); end
    end
  endtask

  task automatic test_flush(input string name, input int drain, input int pct,
                            input int rsp_hold, input bit handshake_done);
    int dev, cycles, stalls; string msg;
    if (!handshake_done) begin
      next_cycle();
      flush_req_valid = 1'b1; stall = 1'($urandom_range(1)); pipe_empty = 1'($urandom_range(1));
      flush_rsp_ready = 1'b0;
      @(negedge clk);
      total++;
      if (flush_req_ready !== 1'b1 || busy !== 1'b0 || init !== 1'b0)
        begin bad++; $display("FAIL %s_accept: got rdy=%b busy=%b init=%b want 1 0 0", name, flush_req_ready, busy, init); end
    end
    for (int d = 0; d <= drain; d++) begin
      next_cycle();
      pipe_empty = (d == drain); stall = 1'($urandom_range(1));
      flush_req_valid = 1'($urandom_range(1)); flush_rsp_ready = 1'($urandom_range(1));
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || init !== 1'b0 || flush_req_ready !== 1'b0 || flush_rsp_valid !== 1'b0)
        begin bad++; $display("FAIL %s_drain: drain cycle %0d got busy=%b init=%b rdy=%b rsp=%b want 1 0 0 0",
                              name, d, busy, init, flush_req_ready, flush_rsp_valid); end
    end
    run_sweep(pct, '0, 1'b0, -1, dev, cycles, stalls, msg);
    check_sweep_result(name, dev, msg);
    for (int h = 0; h <= rsp_hold; h++) begin
      next_cycle();
      flush_rsp_ready = (h == rsp_hold); stall = 1'($urandom_range(1));
      flush_req_valid = 1'($urandom_range(1)); pipe_empty = 1'($urandom_range(1));
      @(negedge clk);
      total++;
      if (flush_rsp_valid !== 1'b1 || busy !== 1'b1 || init !== 1'b0 || flush_req_ready !== 1'b0)
        begin bad++; $display("FAIL %s_rsp: done cycle %0d got rsp=%b busy=%b init=%b rdy=%b want 1 1 0 0",
                              name, h, flush_rsp_valid, busy, init, flush_req_ready); end
    end
    next_cycle();
    flush_rsp_ready = 1'b0; flush_req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (flush_req_ready !== 1'b1 || busy !== 1'b0 || flush_rsp_valid !== 1'b0)
      begin bad++; $display("FAIL %s_return_idle: got rdy=%b busy=%b rsp=%b want 1 0 0", name, flush_req_ready, busy, flush_rsp_valid); end
  endtask

  task automatic test_stall_init();
    int dev, cycles, stalls; string msg;
    apply_reset();
    run_sweep(0, 64'h0000_0000_0000_00E0, 1'b0, -1, dev, cycles, stalls, msg);
    check_sweep_result("stall_init", dev, msg);
    check_idle_after("stall_init", cycles);
    apply_reset();
    run_sweep(40, '0, 1'b0, -1, dev, cycles, stalls, msg);
    check_sweep_result("rand_stall_init", dev, msg);
    check_idle_after("rand_stall_init", cycles);
  endtask

  task automatic test_backpressure();
    int dev, cycles, stalls; string msg;
    apply_reset();
    run_sweep(0, '0, 1'b1, -1, dev, cycles, stalls, msg);
    check_sweep_result("backpressure", dev, msg);
    next_cycle();
    flush_req_valid = 1'b1; pipe_empty = 1'b1; stall = 1'b0;
    @(negedge clk);
    total++;
    if (flush_req_ready !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL backpressure_accept: cycle %0d got rdy=%b busy=%b want 1 0", cycles, flush_req_ready, busy); end
    test_flush("bp_flush", 0, 0, 0, 1'b1);
  endtask

  task automatic test_random_flush();
    for (int k = 0; k < 4; k++)
      test_flush("rand_flush", int'($urandom_range(6)), 25, int'($urandom_range(4)), 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    int dev, cycles, stalls, rsp_seen; string msg;
    next_cycle();
    flush_req_valid = 1'b1; pipe_empty = 1'b1;
    @(negedge clk);
    next_cycle();
    flush_req_valid = 1'b0; pipe_empty = 1'b1;
    run_sweep(0, '0, 1'b0, 17, dev, cycles, stalls, msg);
    total++;
    if (dev !== 0) begin bad++; $display("FAIL midreset_pre_sweep: %0d bad cycles, first %s", dev, msg); end
    next_cycle();
    reset = 1'b1; stall = 1'b0;
    @(negedge clk);
    total++;
    if (init !== 1'b0 || busy !== 1'b1 || line_sel !== '0 || flush_rsp_valid !== 1'b0)
      begin bad++; $display("FAIL midreset_forced: got init=%b busy=%b sel=%0d rsp=%b want 0 1 0 0", init, busy, line_sel, flush_rsp_valid); end
    run_sweep(0, '0, 1'b0, -1, dev, cycles, stalls, msg);
    check_sweep_result("midreset_init", dev, msg);
    rsp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      flush_req_valid = 1'b0; flush_rsp_ready = 1'($urandom_range(1)); stall = 1'($urandom_range(1));
      @(negedge clk);
      if (flush_rsp_valid !== 1'b0) rsp_seen++;
    end
    total++;
    if (rsp_seen !== 0) begin bad++; $display("FAIL midreset_no_rsp: got %0d response cycles want 0", rsp_seen); end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_idle();
    test_flush("flush_empty", 0, 0, 3, 1'b0);
    test_flush("flush_drain", 10, 0, 0, 1'b0);
    test_stall_init();
    test_backpressure();
    test_random_flush();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
